// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, memory request bundle
// and starvation counter width.
package mem_arb_pkg;

  localparam int STARVE_W = 4;
  localparam int MEM_AW   = 32;
  localparam int MEM_DW   = 32;
  localparam int BMASK_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [MEM_AW-1:0]  addr;
    logic [MEM_DW-1:0]  wdata;
    logic [BMASK_W-1:0] bmask;
  } mem_req_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Winner selection between fetch and data: data has priority unless fetch has
// been starved for the limit; a flushing fetch never wins.
module arb_prio_sel (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_if_flush,
  input  logic i_starve_hit,
  output logic o_sel_if,
  output logic o_sel_d
);

  logic if_eligible;

  // A flushed fetch cannot block data through the starvation rule either.
  assign if_eligible = i_if_req & ~i_if_flush;
  assign o_sel_d     = i_d_req & ~(if_eligible & i_starve_hit);
  assign o_sel_if    = if_eligible & ~o_sel_d;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF and LSU with data priority, starvation limit
// and fetch flush. Define MEM_ARB_PERF_EN to add wait/drop performance counters.
// Handshake: a requester holds req and fields until gnt; gnt is a same-cycle
// accept; rvalid is a one-cycle pulse with the response, one transaction in flight.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_if_flush,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  input  logic [3:0]    i_d_bmask,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]   o_if_wait_cnt,
  output logic [31:0]   o_d_wait_cnt,
  output logic [15:0]   o_if_drop_cnt,
`endif
  output logic [1:0]    o_state
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                drop_q, drop_d;
  logic                sel_if, sel_d, starve_hit;
  logic                if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, fetch_dropped;
  logic [DW-1:0]       if_rdata, d_rdata;
  mem_req_t            mem_sel;

  assign starve_hit = (starve_q == STARVE_LIM);

  arb_prio_sel u_prio_sel (
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .i_if_flush   (i_if_flush),
    .i_starve_hit (starve_hit),
    .o_sel_if     (sel_if),
    .o_sel_d      (sel_d)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

  // Everything is gated by reset so outputs drop to zero the moment it asserts.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    drop_d        = drop_q;
    mem_sel       = '0;
    mem_req       = 1'b0;
    if_gnt        = 1'b0;
    d_gnt         = 1'b0;
    if_rvalid     = 1'b0;
    d_rvalid      = 1'b0;
    if_rdata      = '0;
    d_rdata       = '0;
    fetch_dropped = 1'b0;
    if (i_reset) begin
      case (state_q)
        IDLE: begin
          drop_d = 1'b0;
          if (sel_d) begin
            mem_req       = 1'b1;
            d_gnt         = 1'b1;
            mem_sel.we    = i_d_we;
            mem_sel.addr  = i_d_addr;
            mem_sel.wdata = i_d_wdata;
            mem_sel.bmask = i_d_bmask;
            state_d       = WAIT_D;
          end else if (sel_if) begin
            mem_req      = 1'b1;
            if_gnt       = 1'b1;
            mem_sel.addr = i_if_addr;
            state_d      = WAIT_I;
          end
          if (!i_if_req || sel_if)
            starve_d = '0;
          else if (sel_d && !starve_hit)
            starve_d = starve_q + STARVE_W'(1);
        end
        WAIT_I: begin
          if (i_mem_ack) begin
            fetch_dropped = drop_q | i_if_flush;
            if_rvalid     = ~fetch_dropped;
            if_rdata      = i_mem_rdata;
            drop_d        = 1'b0;
            state_d       = IDLE;
          end else if (i_if_flush) begin
            drop_d = 1'b1;
          end
        end
        WAIT_D: begin
          if (i_mem_ack) begin
            d_rvalid = 1'b1;
            d_rdata  = i_mem_rdata;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_d_gnt     = d_gnt;
  assign o_if_rvalid = if_rvalid;
  assign o_d_rvalid  = d_rvalid;
  assign o_if_rdata  = if_rdata;
  assign o_d_rdata   = d_rdata;
  assign o_mem_req   = mem_req;
  assign o_mem_we    = mem_sel.we;
  assign o_mem_addr  = mem_sel.addr;
  assign o_mem_wdata = mem_sel.wdata;
  assign o_mem_bmask = mem_sel.bmask;
  assign o_state     = state_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] if_wait_q, d_wait_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      if_wait_q  <= '0;
      d_wait_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (i_if_req && !if_gnt) if_wait_q <= if_wait_q + 32'd1;
      if (i_d_req && !d_gnt)   d_wait_q  <= d_wait_q + 32'd1;
      if (fetch_dropped && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_if_wait_cnt = if_wait_q;
  assign o_d_wait_cnt  = d_wait_q;
  assign o_if_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: reset, fetch, starvation order, store,
// flush cases, idle ack, reset mid-transaction and optional perf counters.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_if_req, i_if_flush, i_d_req, i_d_we, i_mem_ack;
  logic [AW-1:0] i_if_addr, i_d_addr;
  logic [DW-1:0] i_d_wdata, i_mem_rdata;
  logic [3:0]    i_d_bmask;
  logic          o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid;
  logic          o_mem_req, o_mem_we;
  logic [DW-1:0] o_if_rdata, o_d_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_bmask;
  logic [1:0]    o_state;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   o_if_wait_cnt, o_d_wait_cnt;
  logic [15:0]   o_if_drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_bmask(i_d_bmask),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
`ifdef MEM_ARB_PERF_EN
    .o_if_wait_cnt(o_if_wait_cnt), .o_d_wait_cnt(o_d_wait_cnt),
    .o_if_drop_cnt(o_if_drop_cnt),
`endif
    .o_state(o_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Inputs change 1ns after the rising edge; checks happen 2ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_addr = '0; i_if_flush = 0;
    i_d_req = 0; i_d_we = 0; i_d_addr = '0; i_d_wdata = '0; i_d_bmask = '0;
    i_mem_ack = 0; i_mem_rdata = '0;
  endtask

  task automatic test_reset();
    logic [160:0] outs;
    i_reset = 0;
    idle_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    outs = {o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
            o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask, o_state};
    vectors++; if (outs !== '0) begin miscompares++; $display("FAIL reset_outs got %h exp 0", outs); end
    tick(); i_reset = 1;
    settle();
    vectors++; if (o_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", o_state); end
  endtask

  task automatic test_fetch();
    tick(); i_if_req = 1; i_if_addr = 32'h0000_0010; settle();
    vectors++; if ({o_if_gnt, o_d_gnt, o_mem_req} !== 3'b101) begin miscompares++; $display("FAIL fetch_gnt got %b exp 101", {o_if_gnt, o_d_gnt, o_mem_req}); end
    vectors++; if ({o_mem_we, o_mem_bmask, o_mem_addr} !== {1'b0, 4'h0, 32'h10}) begin miscompares++; $display("FAIL fetch_fields got we=%b bm=%h a=%h exp 0 0 10", o_mem_we, o_mem_bmask, o_mem_addr); end
    tick(); i_if_req = 0; settle();
    vectors++; if ({o_mem_req, o_if_gnt, o_state} !== {2'b00, 2'd1}) begin miscompares++; $display("FAIL fetch_wait got req=%b gnt=%b st=%0d exp 0 0 1", o_mem_req, o_if_gnt, o_state); end
    tick(); i_mem_ack = 1; i_mem_rdata = 32'h0051_3093; settle();
    vectors++; if ({o_if_rvalid, o_d_rvalid, o_if_rdata} !== {2'b10, 32'h0051_3093}) begin miscompares++; $display("FAIL fetch_rdata got v=%b dv=%b d=%h exp 1 0 00513093", o_if_rvalid, o_d_rvalid, o_if_rdata); end
    tick(); i_mem_ack = 0; i_mem_rdata = '0; settle();
    vectors++; if ({o_state, o_if_rvalid} !== 3'b000) begin miscompares++; $display("FAIL fetch_idle got st=%0d v=%b exp 0 0", o_state, o_if_rvalid); end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_if;
    exp_if = 10'b10_0001_0000;  // bit k set means grant k goes to fetch
    for (int k = 0; k < 10; k++) begin
      tick(); i_mem_ack = 0; i_if_req = 1; i_d_req = 1; i_if_addr = 32'h100 + k; i_d_addr = 32'h2000 + k; settle();
      vectors++; if ({o_if_gnt, o_d_gnt} !== {exp_if[k], ~exp_if[k]}) begin miscompares++; $display("FAIL starve_grant_%0d got if=%b d=%b exp if=%b", k, o_if_gnt, o_d_gnt, exp_if[k]); end
      tick(); i_mem_ack = 1; i_mem_rdata = 32'hA000 + k;
      if (k == 9) begin i_if_req = 0; i_d_req = 0; end
      settle();
      vectors++; if ({o_if_rvalid, o_d_rvalid} !== {exp_if[k], ~exp_if[k]}) begin miscompares++; $display("FAIL starve_rvalid_%0d got if=%b d=%b exp if=%b", k, o_if_rvalid, o_d_rvalid, exp_if[k]); end
    end
    tick(); i_mem_ack = 0; i_mem_rdata = '0; settle();
  endtask

  task automatic test_store();
    tick(); i_d_req = 1; i_d_we = 1; i_d_addr = 32'h0000_2004; i_d_wdata = 32'hDEAD_BEEF; i_d_bmask = 4'b0011; settle();
    vectors++; if ({o_d_gnt, o_if_gnt, o_mem_req, o_mem_we} !== 4'b1011) begin miscompares++; $display("FAIL store_gnt got %b exp 1011", {o_d_gnt, o_if_gnt, o_mem_req, o_mem_we}); end
    vectors++; if ({o_mem_addr, o_mem_wdata, o_mem_bmask} !== {32'h0000_2004, 32'hDEAD_BEEF, 4'b0011}) begin miscompares++; $display("FAIL store_fields got %h %h %b exp 00002004 deadbeef 0011", o_mem_addr, o_mem_wdata, o_mem_bmask); end
    tick(); i_d_req = 0; i_d_we = 0; settle();
    vectors++; if ({o_mem_req, o_d_rvalid, o_state} !== {2'b00, 2'd2}) begin miscompares++; $display("FAIL store_wait got req=%b v=%b st=%0d exp 0 0 2", o_mem_req, o_d_rvalid, o_state); end
    tick(); i_mem_ack = 1; settle();
    vectors++; if ({o_d_rvalid, o_if_rvalid} !== 2'b10) begin miscompares++; $display("FAIL store_ack got d=%b if=%b exp 1 0", o_d_rvalid, o_if_rvalid); end
    tick(); i_mem_ack = 0; settle();
    vectors++; if (o_d_rvalid !== 1'b0) begin miscompares++; $display("FAIL store_pulse got %b exp 0", o_d_rvalid); end
  endtask

  task automatic test_flush();
    tick(); i_if_req = 1; i_if_addr = 32'h20; settle();
    vectors++; if (o_if_gnt !== 1'b1) begin miscompares++; $display("FAIL flush_gnt got %b exp 1", o_if_gnt); end
    tick(); i_if_req = 0; i_if_flush = 1; settle();
    tick(); i_if_flush = 0; settle();
    tick(); i_mem_ack = 1; i_mem_rdata = 32'h1111_2222; settle();
    vectors++; if ({o_if_rvalid, o_d_rvalid} !== 2'b00) begin miscompares++; $display("FAIL flush_drop got if=%b d=%b exp 0 0", o_if_rvalid, o_d_rvalid); end
    tick(); i_mem_ack = 0; i_if_req = 1; i_if_addr = 32'h0000_0040; settle();
    vectors++; if ({o_if_gnt, o_mem_addr} !== {1'b1, 32'h40}) begin miscompares++; $display("FAIL flush_next_gnt got g=%b a=%h exp 1 40", o_if_gnt, o_mem_addr); end
    tick(); i_if_req = 0; i_mem_ack = 1; i_mem_rdata = 32'h1234_5678; settle();
    vectors++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h1234_5678}) begin miscompares++; $display("FAIL flush_next_data got v=%b d=%h exp 1 12345678", o_if_rvalid, o_if_rdata); end
    tick(); i_mem_ack = 0; settle();
  endtask

  task automatic test_flush_edges();
    tick(); i_if_req = 1; i_if_flush = 1; i_if_addr = 32'h80; settle();
    vectors++; if ({o_if_gnt, o_mem_req} !== 2'b00) begin miscompares++; $display("FAIL flush_idle got g=%b r=%b exp 0 0", o_if_gnt, o_mem_req); end
    i_d_req = 1; i_d_addr = 32'h3300; #1;
    vectors++; if ({o_d_gnt, o_if_gnt} !== 2'b10) begin miscompares++; $display("FAIL flush_idle_data got d=%b i=%b exp 1 0", o_d_gnt, o_if_gnt); end
    i_d_req = 0; #1;
    tick(); i_if_flush = 0; settle();
    vectors++; if (o_if_gnt !== 1'b1) begin miscompares++; $display("FAIL flush_release got %b exp 1", o_if_gnt); end
    tick(); i_if_req = 0; i_mem_ack = 1; i_if_flush = 1; settle();
    vectors++; if (o_if_rvalid !== 1'b0) begin miscompares++; $display("FAIL flush_ackcycle got %b exp 0", o_if_rvalid); end
    tick(); i_mem_ack = 1; i_if_flush = 0; settle();
    vectors++; if ({o_if_rvalid, o_d_rvalid, o_state} !== 4'b0000) begin miscompares++; $display("FAIL idle_ack got %b exp 0000", {o_if_rvalid, o_d_rvalid, o_state}); end
    tick(); i_mem_ack = 0; settle();
  endtask

  task automatic test_reset_mid();
    logic [160:0] outs;
    tick(); i_d_req = 1; i_d_addr = 32'h3000; i_d_we = 1; i_d_wdata = 32'h5555; i_d_bmask = 4'hF; settle();
    vectors++; if (o_d_gnt !== 1'b1) begin miscompares++; $display("FAIL rmid_gnt got %b exp 1", o_d_gnt); end
    tick(); i_d_req = 0; i_d_we = 0; i_d_wdata = '0; i_d_bmask = '0; i_d_addr = '0; settle();
    i_reset = 0; #1;
    outs = {o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
            o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask, o_state};
    vectors++; if (outs !== '0) begin miscompares++; $display("FAIL rmid_outs got %h exp 0", outs); end
    tick(); i_reset = 1; settle();
    tick(); i_mem_ack = 1; i_mem_rdata = 32'hBAD0_BAD0; settle();
    vectors++; if ({o_if_rvalid, o_d_rvalid, o_state} !== 4'b0000) begin miscompares++; $display("FAIL rmid_late_ack got %b exp 0000", {o_if_rvalid, o_d_rvalid, o_state}); end
    tick(); i_mem_ack = 0; i_mem_rdata = '0; settle();
  endtask

  // Starts right after a reset so perf counters begin from zero.
  task automatic test_perf();
    tick(); i_d_req = 1; i_if_req = 1; i_d_addr = 32'h4000; i_if_addr = 32'h90; settle();
    vectors++; if ({o_d_gnt, o_if_gnt} !== 2'b10) begin miscompares++; $display("FAIL perf_dgnt got %b exp 10", {o_d_gnt, o_if_gnt}); end
    tick(); i_d_req = 0; settle();
    tick(); settle();
    tick(); settle();
    tick(); i_mem_ack = 1; settle();
    tick(); i_mem_ack = 0; settle();
    vectors++; if (o_if_gnt !== 1'b1) begin miscompares++; $display("FAIL perf_ignt got %b exp 1", o_if_gnt); end
    tick(); i_if_req = 0; i_if_flush = 1; settle();
    tick(); i_if_flush = 0; i_mem_ack = 1; settle();
    vectors++; if (o_if_rvalid !== 1'b0) begin miscompares++; $display("FAIL perf_drop got %b exp 0", o_if_rvalid); end
    tick(); i_mem_ack = 0; settle();
`ifdef MEM_ARB_PERF_EN
    vectors++; if (o_if_wait_cnt !== 32'd5) begin miscompares++; $display("FAIL perf_if_wait got %0d exp 5", o_if_wait_cnt); end
    vectors++; if (o_d_wait_cnt !== 32'd0) begin miscompares++; $display("FAIL perf_d_wait got %0d exp 0", o_d_wait_cnt); end
    vectors++; if (o_if_drop_cnt !== 16'd1) begin miscompares++; $display("FAIL perf_drop_cnt got %0d exp 1", o_if_drop_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starvation();
    test_store();
    test_flush();
    test_flush_edges();
    test_reset_mid();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
